muldiv_seq_ctrl: RTL and testbench
==================================

// Module: muldiv_seq_ctrl
// PURPOSE
//  Sequencer for EX-stage multi-cycle MULT/MULTU/DIV/DIVU. Latches operands, drives the
//  iterative divider (start/done handshake) and the pipelined multiplier, stalls the
//  pipeline until the result is ready, then issues one HILO write. Sits between the
//  ALU decode and the div/mul units; replaces the ALU's combinational stall generation.
// PARAMETERS
//  MUL_LAT  2  multiplier pipeline depth in cycles (legal 1..15)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   reset, synchronous, active-high
//  md_req       in   1   EX holds a mul/div op; held stable by EX while stall=1
//  md_op        in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  opd_a        in   32  rs operand (dividend / multiplicand)
//  opd_b        in   32  rt operand (divisor / multiplier)
//  flush        in   1   exception/ERET flush; cancels in-flight op
//  div_start    out  1   one-cycle start pulse to divider
//  div_cancel   out  1   one-cycle abort pulse to divider
//  div_sign     out  1   1 = signed divide
//  div_a/div_b  out  32  latched divider operands, stable from start to done
//  div_done     in   1   divider result valid (sampled in DIV_WAIT only)
//  div_quot/div_rem in 32 divider results
//  mul_sign     out  1   1 = signed multiply
//  mul_a/mul_b  out  32  latched multiplier operands
//  mul_prod     in   64  multiplier product, valid MUL_LAT cycles after operands latched
//  stall        out  1   freeze IF/ID/EX
//  busy         out  1   state != IDLE
//  hilo_we      out  1   one-cycle HILO write enable
//  hilo_wdata   out  64  {hi,lo}: mult -> product; div -> {rem,quot}
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (stall, busy, hilo_we, div_start, div_cancel, operands,
//   hilo_wdata). Reset mid-operation abandons it: no hilo_we, no div_cancel pulse.
//  States IDLE, MUL_WAIT, DIV_WAIT, DONE.
//  IDLE: md_req&~flush at cycle T -> latch operands, sign = ~md_op[0]; stall=1 at T
//   (combinational from md_req). mult -> MUL_WAIT, cnt=MUL_LAT; div -> DIV_WAIT, div_start=1 at T+1.
//  MUL_WAIT: cnt decrements each cycle; at cnt==1 capture mul_prod into hilo_wdata, -> DONE.
//   MUL_WAIT lasts MUL_LAT cycles; DONE at T+MUL_LAT+1; stall high T..T+MUL_LAT.
//  DIV_WAIT: div_done=1 -> capture {div_rem,div_quot}, -> DONE. No timeout.
//  DONE: stall=0, hilo_we=1 for exactly one cycle, -> IDLE. md_req in DONE is ignored
//   (belongs to the retiring instr); a new op is accepted from IDLE next cycle at earliest.
//  stall = (IDLE & md_req & ~flush) | MUL_WAIT | DIV_WAIT.
//  flush (any cycle, priority over all else): -> IDLE next cycle, stall=0 that cycle,
//   hilo_we suppressed even in DONE; if state is DIV_WAIT, div_cancel=1 that cycle.
//  flush and div_done same cycle: flush wins, no write.
//  Operands/sign never change between acceptance and DONE.
// CONFIGURATION
//  DIV_ZERO_BYPASS_EN defined: DIV/DIVU with opd_b==0 skips the divider (no div_start),
//   goes IDLE->DONE, writes hilo_wdata={opd_a, 32'hFFFF_FFFF}; stall only at T.
//  Undefined: divide-by-zero runs through the divider like any other divide.
// TESTING
//  MULT a=-3 b=5, MUL_LAT=2 -> stall 3 cycles, hilo_we 1 cycle, wdata=64'hFFFF_FFFF_FFFF_FFF1.
//  DIV a=-7 b=2, div_done 34 cycles after start -> single div_start, div_sign=1,
//   wdata={32'hFFFF_FFFF,32'hFFFF_FFFD}.
//  DIVU a=100 b=7, flush 5 cycles into DIV_WAIT -> div_cancel 1 pulse, IDLE next, no hilo_we.
//  DIVU a=9 b=0 -> macro on: no div_start, hilo_we at T+1, wdata={9,32'hFFFF_FFFF};
//   macro off: div_start issued, normal completion.
//  MULTU then DIV back-to-back -> two hilo_we, 1 IDLE cycle between, stall never glitches low early.
//  rst asserted in MUL_WAIT -> all outputs 0 next cycle, no hilo_we; next MULT completes normally.

Source files
------------

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: EX-stage sequencer for MULT/MULTU/DIV/DIVU.
// Latches operands, drives the iterative divider (start/done/cancel) and the
// pipelined multiplier, stalls the pipeline while the result is pending, and
// issues a single HILO write when the result is ready.
// Optional feature macro: DIV_ZERO_BYPASS_EN. When it is defined, a divide by
// zero skips the divider and writes {opd_a, 32'hFFFF_FFFF} directly.
module muldiv_seq_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_req,
  input  logic [1:0]  md_op,
  input  logic [31:0] opd_a,
  input  logic [31:0] opd_b,
  input  logic        flush,
  output logic        div_start,
  output logic        div_cancel,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_prod,
  output logic        stall,
  output logic        busy,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        accept;
  logic        bypass;

  // Divide-by-zero detection used only when the bypass feature is built in.
  always_comb begin
`ifdef DIV_ZERO_BYPASS_EN
    bypass = md_op[1] && (opd_b == 32'd0);
`else
    bypass = 1'b0;
`endif
  end

  // Next-state decode plus the combinational handshake outputs; flush overrides all.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    stall      = 1'b0;
    hilo_we    = 1'b0;
    div_cancel = 1'b0;
    case (state)
      IDLE: begin
        if (md_req && !flush) begin
          accept = 1'b1;
          stall  = 1'b1;
          if (!md_op[1]) begin
            state_next = MUL_WAIT;
          end else if (bypass) begin
            state_next = DONE;
          end else begin
            state_next = DIV_WAIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      MUL_WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd1) begin
          state_next = DONE;
        end else begin
          state_next = MUL_WAIT;
        end
      end
      DIV_WAIT: begin
        stall = 1'b1;
        if (div_done) begin
          state_next = DONE;
        end else begin
          state_next = DIV_WAIT;
        end
      end
      DONE: begin
        // md_req here still belongs to the retiring instruction; ignore it.
        hilo_we    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (flush) begin
      state_next = IDLE;
      accept     = 1'b0;
      stall      = 1'b0;
      hilo_we    = 1'b0;
      div_cancel = (state == DIV_WAIT);
    end else begin
      div_cancel = 1'b0;
    end

    // A reset abandons the operation silently: no write, no cancel pulse.
    if (rst) begin
      stall      = 1'b0;
      hilo_we    = 1'b0;
      div_cancel = 1'b0;
    end else begin
      div_cancel = div_cancel;
    end
  end

  assign busy = (state != IDLE);

  // State register and the one-cycle divider start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_start <= 1'b0;
    end else begin
      state     <= state_next;
      div_start <= accept && md_op[1] && !bypass;
    end
  end

  // Operand/sign latches: written only on acceptance, so they stay put until DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a    <= 32'd0;
      mul_b    <= 32'd0;
      mul_sign <= 1'b0;
      div_a    <= 32'd0;
      div_b    <= 32'd0;
      div_sign <= 1'b0;
    end else if (accept) begin
      if (!md_op[1]) begin
        mul_a    <= opd_a;
        mul_b    <= opd_b;
        mul_sign <= ~md_op[0];
      end else begin
        div_a    <= opd_a;
        div_b    <= opd_b;
        div_sign <= ~md_op[0];
      end
    end
  end

  // Multiplier latency counter: loaded on accept, counts down through MUL_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept && !md_op[1]) begin
      cnt <= 4'(MUL_LAT);
    end else if ((state == MUL_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Result capture into the HILO write-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hilo_wdata <= 64'd0;
    end else if (!flush) begin
      if (accept && bypass) begin
        hilo_wdata <= {opd_a, 32'hFFFF_FFFF};
      end else if ((state == MUL_WAIT) && (cnt == 4'd1)) begin
        hilo_wdata <= mul_prod;
      end else if ((state == DIV_WAIT) && div_done) begin
        hilo_wdata <= {div_rem, div_quot};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl with behavioural divider and
// multiplier stubs and an arithmetic reference model for HILO results.
module tb_muldiv_seq_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_req;
  logic [1:0]  md_op;
  logic [31:0] opd_a;
  logic [31:0] opd_b;
  logic        flush;
  logic        div_start;
  logic        div_cancel;
  logic        div_sign;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        mul_sign;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_prod;
  logic        stall;
  logic        busy;
  logic        hilo_we;
  logic [63:0] hilo_wdata;

  int checks   = 0;
  int failures = 0;
  int div_lat  = 34;
  int div_cnt  = 0;

  // results gathered by run_op
  int          r_stall, r_we, r_start, r_cancel, r_we_cyc, r_start_cyc;
  logic [63:0] r_wdata;
  logic        r_sign, r_busy0, r_busy1, r_busy_tail, r_glitch, r_timeout;

  always #5 clk = ~clk;

  muldiv_seq_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .md_req(md_req), .md_op(md_op),
    .opd_a(opd_a), .opd_b(opd_b), .flush(flush),
    .div_start(div_start), .div_cancel(div_cancel), .div_sign(div_sign),
    .div_a(div_a), .div_b(div_b), .div_done(div_done),
    .div_quot(div_quot), .div_rem(div_rem),
    .mul_sign(mul_sign), .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
    .stall(stall), .busy(busy), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata)
  );

  // Reference: HILO value of a multiply, {hi,lo} = full 64-bit product
  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (op[0] == 1'b0) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    return 64'(sa * sb);
  endfunction

  // Reference: HILO value of a divide, {hi,lo} = {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op[0] == 1'b0) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Divider stub: div_done pulses div_lat cycles after div_start
  always @(posedge clk) begin
    if (rst || div_cancel) div_cnt <= 0;
    else if (div_start) div_cnt <= div_lat;
    else if (div_cnt != 0) div_cnt <= div_cnt - 1;
  end
  assign div_done = (div_cnt == 1);
  assign {div_rem, div_quot} = ref_div({1'b1, ~div_sign}, div_a, div_b);
  assign mul_prod = ref_mul({1'b0, ~mul_sign}, mul_a, mul_b);

  // Presents one op (cycle 0 = acceptance cycle T) and records what happens.
  // Called and returns at posedge+1.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input bit keep);
    int c;
    bit fin;
    bit prev;
    r_stall = 0; r_we = 0; r_start = 0; r_cancel = 0;
    r_we_cyc = -1; r_start_cyc = -1; r_wdata = 64'd0;
    r_sign = 1'b0; r_busy0 = 1'b0; r_busy1 = 1'b0; r_busy_tail = 1'b0;
    r_glitch = 1'b0; r_timeout = 1'b0;
    md_req = 1'b1; md_op = op; opd_a = a; opd_b = b;
    c = 0; fin = 0; prev = 0;
    while (!fin) begin
      flush = (c == flush_at);
      @(negedge clk);
      if (stall) begin
        r_stall++;
        if (c > 0 && !prev) r_glitch = 1'b1;
      end
      prev = stall;
      if (hilo_we) begin r_we++; r_we_cyc = c; r_wdata = hilo_wdata; end
      if (div_start) begin r_start++; r_start_cyc = c; end
      if (div_cancel) r_cancel++;
      if (c == 0) r_busy0 = busy;
      if (c == 1) begin
        r_busy1 = busy;
        r_sign  = op[1] ? div_sign : mul_sign;
      end
      @(posedge clk); #1;
      flush = 1'b0;
      if (r_we != 0 || c == flush_at) fin = 1;
      else if (c >= 300) begin fin = 1; r_timeout = 1'b1; end
      c++;
    end
    if (!keep) begin
      md_req = 1'b0;
      for (int t = 0; t < 3; t++) begin
        @(negedge clk);
        if (t == 0) r_busy_tail = busy;
        if (stall) r_stall++;
        if (hilo_we) begin r_we++; r_we_cyc = c + t; end
        if (div_start) r_start++;
        if (div_cancel) r_cancel++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; md_req = 1'b0; md_op = 2'd0; opd_a = 32'd0; opd_b = 32'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if ({stall, busy, hilo_we, div_start, div_cancel, div_sign, mul_sign} !== 7'd0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {stall, busy, hilo_we, div_start, div_cancel, div_sign, mul_sign});
    end
    checks++;
    if ({div_a, div_b, mul_a, mul_b, hilo_wdata} !== 192'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {div_a, div_b, mul_a, mul_b, hilo_wdata});
    end
    checks++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_mult();
    logic [1:0]  op;
    logic [31:0] a, b;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, 1'b0);
    if (r_wdata !== 64'hFFFF_FFFF_FFFF_FFF1) begin failures++; $display("FAIL mult_vec_wdata got=%h exp=%h", r_wdata, 64'hFFFF_FFFF_FFFF_FFF1); end
    checks++;
    if (r_stall !== MUL_LAT + 1) begin failures++; $display("FAIL mult_vec_stall got=%0d exp=%0d", r_stall, MUL_LAT + 1); end
    checks++;
    if (r_we !== 1 || r_we_cyc !== MUL_LAT + 1) begin failures++; $display("FAIL mult_vec_we got=%0d@%0d exp=1@%0d", r_we, r_we_cyc, MUL_LAT + 1); end
    checks++;
    if ({r_sign, r_busy1, r_busy_tail, r_glitch, r_timeout} !== 5'b11000 || r_start !== 0) begin
      failures++; $display("FAIL mult_vec_flags got=%b start=%0d exp=11000 start=0", {r_sign, r_busy1, r_busy_tail, r_glitch, r_timeout}, r_start);
    end
    checks++;
    for (int i = 0; i < 6; i++) begin
      op = {1'b0, 1'($urandom_range(0, 1))};
      a = $urandom; b = $urandom;
      run_op(op, a, b, -1, 1'b0);
      if (r_wdata !== ref_mul(op, a, b)) begin failures++; $display("FAIL mult_rand_wdata op=%0d got=%h exp=%h", op, r_wdata, ref_mul(op, a, b)); end
      checks++;
      if (r_stall !== MUL_LAT + 1 || r_we !== 1 || r_we_cyc !== MUL_LAT + 1) begin
        failures++; $display("FAIL mult_rand_timing stall=%0d we=%0d@%0d exp=%0d 1@%0d", r_stall, r_we, r_we_cyc, MUL_LAT + 1, MUL_LAT + 1);
      end
      checks++;
      if (r_sign !== ~op[0]) begin failures++; $display("FAIL mult_rand_sign got=%b exp=%b", r_sign, ~op[0]); end
      checks++;
    end
  endtask

  task automatic test_div();
    logic [1:0]  op;
    logic [31:0] a, b;
    div_lat = 34;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    if (r_wdata !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin failures++; $display("FAIL div_vec_wdata got=%h exp=%h", r_wdata, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
    checks++;
    if (r_start !== 1 || r_start_cyc !== 1 || r_sign !== 1'b1) begin
      failures++; $display("FAIL div_vec_start got=%0d@%0d sign=%b exp=1@1 sign=1", r_start, r_start_cyc, r_sign);
    end
    checks++;
    if (r_stall !== 36 || r_we !== 1 || r_we_cyc !== 36 || r_timeout) begin
      failures++; $display("FAIL div_vec_timing stall=%0d we=%0d@%0d exp=36 1@36", r_stall, r_we, r_we_cyc);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      op = {1'b1, 1'($urandom_range(0, 1))};
      a = $urandom; b = $urandom;
      if (b == 32'd0) b = 32'd3;
      if (i == 0) b = {28'd0, 4'($urandom_range(1, 15))};
      div_lat = $urandom_range(1, 20);
      run_op(op, a, b, -1, 1'b0);
      if (r_wdata !== ref_div(op, a, b)) begin failures++; $display("FAIL div_rand_wdata op=%0d got=%h exp=%h", op, r_wdata, ref_div(op, a, b)); end
      checks++;
      if (r_stall !== div_lat + 2 || r_we !== 1 || r_we_cyc !== div_lat + 2 || r_start !== 1) begin
        failures++; $display("FAIL div_rand_timing lat=%0d stall=%0d we=%0d@%0d start=%0d", div_lat, r_stall, r_we, r_we_cyc, r_start);
      end
      checks++;
      if (r_sign !== ~op[0]) begin failures++; $display("FAIL div_rand_sign got=%b exp=%b", r_sign, ~op[0]); end
      checks++;
    end
  endtask

  task automatic test_flush();
    div_lat = 34;
    run_op(2'b11, 32'd100, 32'd7, 6, 1'b0);
    if (r_cancel !== 1 || r_we !== 0 || r_start !== 1) begin
      failures++; $display("FAIL flush_div cancel=%0d we=%0d start=%0d exp=1 0 1", r_cancel, r_we, r_start);
    end
    checks++;
    if (r_stall !== 6 || r_busy_tail !== 1'b0) begin
      failures++; $display("FAIL flush_div_stall stall=%0d busy=%b exp=6 0", r_stall, r_busy_tail);
    end
    checks++;
    run_op(2'b00, $urandom, $urandom, MUL_LAT + 1, 1'b0);
    if (r_we !== 0 || r_cancel !== 0 || r_busy_tail !== 1'b0) begin
      failures++; $display("FAIL flush_done we=%0d cancel=%0d busy=%b exp=0 0 0", r_we, r_cancel, r_busy_tail);
    end
    checks++;
    div_lat = 3;
    run_op(2'b10, $urandom, 32'd5, 4, 1'b0);
    if (r_we !== 0 || r_cancel !== 1) begin
      failures++; $display("FAIL flush_vs_done we=%0d cancel=%0d exp=0 1", r_we, r_cancel);
    end
    checks++;
    run_op(2'b01, $urandom, $urandom, 0, 1'b0);
    if (r_stall !== 0 || r_we !== 0 || r_busy_tail !== 1'b0) begin
      failures++; $display("FAIL flush_idle stall=%0d we=%0d busy=%b exp=0 0 0", r_stall, r_we, r_busy_tail);
    end
    checks++;
  endtask

  task automatic test_div_zero();
    div_lat = 10;
    run_op(2'b11, 32'd9, 32'd0, -1, 1'b0);
    if (r_wdata !== {32'd9, 32'hFFFF_FFFF} || r_we !== 1) begin
      failures++; $display("FAIL divzero_wdata got=%h we=%0d exp=%h 1", r_wdata, r_we, {32'd9, 32'hFFFF_FFFF});
    end
    checks++;
`ifdef DIV_ZERO_BYPASS_EN
    if (r_start !== 0 || r_we_cyc !== 1 || r_stall !== 1) begin
      failures++; $display("FAIL divzero_bypass start=%0d we@%0d stall=%0d exp=0 1 1", r_start, r_we_cyc, r_stall);
    end
`else
    if (r_start !== 1 || r_we_cyc !== 12 || r_stall !== 12) begin
      failures++; $display("FAIL divzero_normal start=%0d we@%0d stall=%0d exp=1 12 12", r_start, r_we_cyc, r_stall);
    end
`endif
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    int          we1, cyc1;
    logic [63:0] w1;
    logic        g1;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom | 32'd1;
    run_op(2'b01, a1, b1, -1, 1'b1);
    we1 = r_we; cyc1 = r_we_cyc; w1 = r_wdata; g1 = r_glitch;
    div_lat = 5;
    run_op(2'b10, a2, b2, -1, 1'b0);
    if (we1 !== 1 || cyc1 !== MUL_LAT + 1 || w1 !== ref_mul(2'b01, a1, b1) || g1) begin
      failures++; $display("FAIL b2b_first we=%0d@%0d got=%h exp=1@%0d %h", we1, cyc1, w1, MUL_LAT + 1, ref_mul(2'b01, a1, b1));
    end
    checks++;
    if (r_busy0 !== 1'b0 || r_stall !== 7 || r_glitch || r_start_cyc !== 1) begin
      failures++; $display("FAIL b2b_second busy0=%b stall=%0d glitch=%b start@%0d exp=0 7 0 1", r_busy0, r_stall, r_glitch, r_start_cyc);
    end
    checks++;
    if (r_we !== 1 || r_wdata !== ref_div(2'b10, a2, b2)) begin
      failures++; $display("FAIL b2b_second_wdata we=%0d got=%h exp=1 %h", r_we, r_wdata, ref_div(2'b10, a2, b2));
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    int          stray;
    md_req = 1'b1; md_op = 2'b00; opd_a = $urandom; opd_b = $urandom;
    @(posedge clk); #1;
    rst = 1'b1; md_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    if ({stall, busy, hilo_we, div_start, div_cancel, div_sign, mul_sign} !== 7'd0 ||
        {div_a, div_b, mul_a, mul_b, hilo_wdata} !== 192'd0) begin
      failures++; $display("FAIL rst_mid_outputs ctrl=%b data=%h exp=0", {stall, busy, hilo_we, div_start, div_cancel, div_sign, mul_sign}, {div_a, div_b, mul_a, mul_b, hilo_wdata});
    end
    checks++;
    stray = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (hilo_we) stray++;
    end
    if (stray !== 0) begin failures++; $display("FAIL rst_mid_we got=%0d exp=0", stray); end
    checks++;
    @(posedge clk); #1;
    a = $urandom; b = $urandom;
    run_op(2'b00, a, b, -1, 1'b0);
    if (r_wdata !== ref_mul(2'b00, a, b) || r_we !== 1 || r_we_cyc !== MUL_LAT + 1) begin
      failures++; $display("FAIL rst_mid_next got=%h we=%0d@%0d exp=%h 1@%0d", r_wdata, r_we, r_we_cyc, ref_mul(2'b00, a, b), MUL_LAT + 1);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
